// File: rtl/serial_mag_comp_pkg.sv
// Shared constants for the bit-serial magnitude comparator: FSM encodings,
// default operand width and the packed verdict type.
package serial_mag_comp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned COMP_WIDTH_DEF = 8;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } verdict_t;

  localparam verdict_t VERDICT_EQ = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

endpackage

// File: rtl/serial_mag_comp_bit_cell.sv
// Single-bit magnitude compare cell; purely combinational, exactly one of
// g/e/l is high for any defined input pair.
module comp_bit_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic e,
  output logic l
);

  always_comb begin
    g = a & ~b;
    l = ~a & b;
    e = ~(a ^ b);
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator: latches A/B on start, walks them MSB-first
// through one comp_bit_cell, and registers a gt/eq/lt verdict with a done pulse.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = COMP_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned     IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_reg_q,   a_reg_d;
  logic [WIDTH-1:0] b_reg_q,   b_reg_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  verdict_t         verdict_q, verdict_d;

  logic bit_g;
  logic bit_e;
  logic bit_l;

  comp_bit_cell u_cell (
    .a (a_reg_q[idx_q]),
    .b (b_reg_q[idx_q]),
    .g (bit_g),
    .e (bit_e),
    .l (bit_l)
  );

  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    idx_d     = idx_q;
    verdict_d = verdict_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_reg_d = a_in;
          b_reg_d = b_in;
          idx_d   = IDX_MSB;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // idx==0 is tested before decrementing, so idx never wraps.
        if (!bit_e) begin
          verdict_d = '{gt: bit_g, eq: 1'b0, lt: bit_l};
          state_d   = ST_DONE;
        end else if (idx_q == '0) begin
          verdict_d = VERDICT_EQ;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy/done are flopped from the next-state decode so every output is a register.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      idx_q     <= IDX_MSB;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      verdict_q <= '0;
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      verdict_q <= verdict_d;
    end
  end

  always_comb begin
    busy = busy_q;
    done = done_q;
    gt   = verdict_q.gt;
    eq   = verdict_q.eq;
    lt   = verdict_q.lt;
  end

endmodule
